// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// One requester is granted at a time. The grant is released on DONE, when
// the owner drops its request, or when the hold limit is reached.
// S1/S0 keep the last granted index while idle, so the mux output does not
// fall back to input A between grants.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic       VALID,
    output logic       S0,
    output logic       S1,
    output logic       TIMEOUT
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t     state;
    logic [1:0] last;
    logic [7:0] hcnt;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       rel_any;

    // Rotating priority search starting just after the most recent grant
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Release conditions for the current owner
    always_comb begin
        rel_done = DONE;
        rel_drop = ~REQ[last];
        rel_hold = (hcnt == 8'(HOLD_MAX));
        rel_any  = rel_done | rel_drop | rel_hold;
    end

    // Arbiter FSM with registered grant, select and timeout outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            last    <= 2'd3;
            hcnt    <= '0;
            GNT     <= '0;
            VALID   <= 1'b0;
            S1      <= 1'b0;
            S0      <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (found) begin
                        GNT      <= 4'b0001 << win;
                        VALID    <= 1'b1;
                        {S1, S0} <= win;
                        last     <= win;
                        hcnt     <= 8'd1;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (rel_any) begin
                        GNT     <= '0;
                        VALID   <= 1'b0;
                        TIMEOUT <= rel_hold & ~rel_done & ~rel_drop;
                        state   <= IDLE;
                    end else begin
                        hcnt    <= hcnt + 8'd1;
                        TIMEOUT <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. The stimulus process pushes the
// hand-computed expected outputs for each clock edge into a scoreboard
// queue; a monitor pops and compares on the following falling edge.
module tb_mux4_rr_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic       VALID;
    logic       S0;
    logic       S1;
    logic       TIMEOUT;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       to;
    } exp_t;

    exp_t sb[$];

    mux4_rr_arbiter #(.HOLD_MAX(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .VALID   (VALID),
        .S0      (S0),
        .S1      (S1),
        .TIMEOUT (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and record the outputs expected after the edge
    task automatic step(input logic [3:0] req, input logic done,
                        input logic [3:0] g, input logic [1:0] s, input logic t);
        exp_t e;
        REQ  = req;
        DONE = done;
        @(posedge CLK);
        e.gnt = g;
        e.sel = s;
        e.to  = t;
        sb.push_back(e);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest scoreboard entry
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gnt",     {4'b0, GNT},     {4'b0, e.gnt});
            check("valid",   {7'b0, VALID},   {7'b0, (e.gnt != 4'b0)});
            check("sel",     {6'b0, S1, S0},  {6'b0, e.sel});
            check("timeout", {7'b0, TIMEOUT}, {7'b0, e.to});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        REQ   = 4'b1111;
        DONE  = 1'b0;

        // Reset held with all requests active
        #22;
        check("rst_gnt",   {4'b0, GNT},    8'h00);
        check("rst_valid", {7'b0, VALID},  8'h00);
        check("rst_sel",   {6'b0, S1, S0}, 8'h00);
        check("rst_to",    {7'b0, TIMEOUT}, 8'h00);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Round-robin rotation, owner pulses DONE on its first cycle
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);

        // Skip non-requesters: last = 0, REQ = 1001
        step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
        step(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0);
        step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);

        // Hold timeout: 8 grant cycles, then a TIMEOUT pulse, then regrant
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 7; i++) step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b1);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);

        // Owner drops its request during grant cycle 3
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
        // Select holds the previous index while idle
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

        // DONE coincident with the hold limit: no TIMEOUT
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 7; i++) step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);

        // Mid-grant asynchronous reset
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("async_gnt",   {4'b0, GNT},     8'h00);
        check("async_valid", {7'b0, VALID},   8'h00);
        check("async_sel",   {6'b0, S1, S0},  8'h00);
        check("async_to",    {7'b0, TIMEOUT}, 8'h00);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // Pointer restarts at 3, so A wins first again
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);

        @(negedge CLK);
        #1;
        check("sb_drain", 8'(sb.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
